// File: rtl/sound_ram_if.sv
// CPU-side bus of the sound RAM controller: request qualifiers, write data,
// registered read data and the ready/ack handshake.
interface sound_ram_if;
    logic [15:0] cpu_addr;
    logic        cpu_vma;
    logic        cpu_rw;
    logic        cpu_e;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic        cpu_ready;

    modport master (
        output cpu_addr, cpu_vma, cpu_rw, cpu_e, cpu_wdata,
        input  cpu_rdata, cpu_ack, cpu_ready
    );

    modport slave (
        input  cpu_addr, cpu_vma, cpu_rw, cpu_e, cpu_wdata,
        output cpu_rdata, cpu_ack, cpu_ready
    );
endinterface

// File: rtl/sound_ram_ctrl.sv
// Bridges a strobed 8-bit CPU bus onto a 128-byte registered RAM window.
// Optional power-up zero fill of the RAM is enabled by defining SOUND_RAM_CLEAR_EN.
module sound_ram_ctrl #(
    parameter logic [15:0] BASE_ADDR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    sound_ram_if.slave  bus,
    output logic [6:0]  ram_address,
    output logic        ram_cs,
    output logic        ram_rw,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata,
    output logic        clear_done
);

    typedef enum logic [2:0] {
        ST_CLEAR = 3'd0,
        ST_IDLE  = 3'd1,
        ST_WRITE = 3'd2,
        ST_READ1 = 3'd3,
        ST_READ2 = 3'd4
    } state_t;

    state_t      state_r, state_s;
    logic [6:0]  ram_address_r, ram_address_s;
    logic        ram_cs_r, ram_cs_s;
    logic        ram_rw_r, ram_rw_s;
    logic [7:0]  ram_wdata_r, ram_wdata_s;
    logic [7:0]  cpu_rdata_r, cpu_rdata_s;
    logic        cpu_ack_r, cpu_ack_s;
    logic        hit_s;

`ifdef SOUND_RAM_CLEAR_EN
    logic [7:0]  clr_cnt_r, clr_cnt_s;
    logic        clear_done_r, clear_done_s;
    localparam state_t RESET_STATE = ST_CLEAR;
`else
    localparam state_t RESET_STATE = ST_IDLE;
`endif

    assign bus.cpu_ready = (state_r == ST_IDLE);
    assign hit_s = bus.cpu_e & bus.cpu_vma & bus.cpu_ready &
                   (bus.cpu_addr[15:7] == BASE_ADDR[15:7]);

    // Next-state and next-output decode; ram_cs defaults low so it can only
    // pulse for one cycle per accepted request.
    always_comb begin
        state_s       = state_r;
        ram_address_s = ram_address_r;
        ram_cs_s      = 1'b0;
        ram_rw_s      = 1'b1;
        ram_wdata_s   = ram_wdata_r;
        cpu_rdata_s   = cpu_rdata_r;
        cpu_ack_s     = 1'b0;
`ifdef SOUND_RAM_CLEAR_EN
        clr_cnt_s     = clr_cnt_r;
        clear_done_s  = clear_done_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (hit_s) begin
                    ram_cs_s      = 1'b1;
                    ram_rw_s      = bus.cpu_rw;
                    ram_address_s = bus.cpu_addr[6:0];
                    if (bus.cpu_rw) begin
                        state_s = ST_READ1;
                    end else begin
                        ram_wdata_s = bus.cpu_wdata;
                        state_s     = ST_WRITE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WRITE: begin
                cpu_ack_s = 1'b1;
                state_s   = ST_IDLE;
            end
            ST_READ1: begin
                state_s = ST_READ2;
            end
            ST_READ2: begin
                cpu_rdata_s = ram_rdata;
                cpu_ack_s   = 1'b1;
                state_s     = ST_IDLE;
            end
`ifdef SOUND_RAM_CLEAR_EN
            ST_CLEAR: begin
                // Counter bit 7 marks that all 128 locations have been written.
                if (!clr_cnt_r[7]) begin
                    ram_cs_s      = 1'b1;
                    ram_rw_s      = 1'b0;
                    ram_address_s = clr_cnt_r[6:0];
                    ram_wdata_s   = 8'h00;
                    clr_cnt_s     = clr_cnt_r + 8'd1;
                end else begin
                    clear_done_s = 1'b1;
                    state_s      = ST_IDLE;
                end
            end
`endif
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= RESET_STATE;
            ram_address_r <= 7'd0;
            ram_cs_r      <= 1'b0;
            ram_rw_r      <= 1'b1;
            ram_wdata_r   <= 8'h00;
            cpu_rdata_r   <= 8'h00;
            cpu_ack_r     <= 1'b0;
`ifdef SOUND_RAM_CLEAR_EN
            clr_cnt_r     <= 8'd0;
            clear_done_r  <= 1'b0;
`endif
        end else begin
            state_r       <= state_s;
            ram_address_r <= ram_address_s;
            ram_cs_r      <= ram_cs_s;
            ram_rw_r      <= ram_rw_s;
            ram_wdata_r   <= ram_wdata_s;
            cpu_rdata_r   <= cpu_rdata_s;
            cpu_ack_r     <= cpu_ack_s;
`ifdef SOUND_RAM_CLEAR_EN
            clr_cnt_r     <= clr_cnt_s;
            clear_done_r  <= clear_done_s;
`endif
        end
    end

    assign ram_address   = ram_address_r;
    assign ram_cs        = ram_cs_r;
    assign ram_rw        = ram_rw_r;
    assign ram_wdata     = ram_wdata_r;
    assign bus.cpu_rdata = cpu_rdata_r;
    assign bus.cpu_ack   = cpu_ack_r;
`ifdef SOUND_RAM_CLEAR_EN
    assign clear_done    = clear_done_r;
`else
    assign clear_done    = 1'b1;
`endif

endmodule

// File: tb/tb_sound_ram_ctrl.sv
// Directed, table-driven bench for sound_ram_ctrl with a registered RAM model;
// covers the SOUND_RAM_CLEAR_EN fill when that macro is defined.
module tb_sound_ram_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  ram_address;
    logic        ram_cs;
    logic        ram_rw;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata = 8'h00;
    logic        clear_done;
    logic [7:0]  mem [128];
    logic        prev_cs = 1'b0;
    int          n_cmp = 0;
    int          n_err = 0;

    sound_ram_if bus ();

    sound_ram_ctrl #(.BASE_ADDR(16'h0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .ram_address (ram_address),
        .ram_cs      (ram_cs),
        .ram_rw      (ram_rw),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata),
        .clear_done  (clear_done)
    );

    always #5 clk = ~clk;

    // Registered RAM: data appears one clock after address/cs.
    always @(posedge clk) begin
        if (ram_cs) begin
            if (!ram_rw) mem[ram_address] <= ram_wdata;
            else         ram_rdata <= mem[ram_address];
        end
    end

    typedef struct {
        logic        rw;
        logic [15:0] addr;
        logic [7:0]  wd;
        logic        vma;
        logic        hit;
        logic [7:0]  rd;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Outside the clear sequence ram_cs must never stay high two cycles.
    always @(negedge clk) begin
        if (rst_n && clear_done && ram_cs) begin
            check("cs_single_cycle", {31'd0, prev_cs}, 32'd0);
        end
        prev_cs <= ram_cs;
    end

    // Called at a negedge: one cpu_e strobe, then watch five cycles.
    task automatic access(input logic rw, input logic [15:0] addr, input logic [7:0] wd,
                          input logic vma, output int ack_at, output int cs_n,
                          output logic [6:0] cs_addr, output logic [7:0] cs_wd);
        bus.cpu_rw = rw; bus.cpu_addr = addr; bus.cpu_wdata = wd;
        bus.cpu_vma = vma; bus.cpu_e = 1'b1;
        ack_at = -1; cs_n = 0; cs_addr = 7'd0; cs_wd = 8'h00;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            if (j == 0) bus.cpu_e = 1'b0;
            if (ram_cs) begin
                cs_n++; cs_addr = ram_address; cs_wd = ram_wdata;
            end
            if (bus.cpu_ack && ack_at < 0) ack_at = j;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int ack_at, cs_n, acks;
        logic [6:0] cs_addr;
        logic [7:0] cs_wd;
        logic ok;

        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        vecs[0]  = '{1'b0, 16'h0042, 8'hA5, 1'b1, 1'b1, 8'h00};
        vecs[1]  = '{1'b1, 16'h0042, 8'h00, 1'b1, 1'b1, 8'hA5};
        vecs[2]  = '{1'b0, 16'h007F, 8'h3C, 1'b1, 1'b1, 8'hA5};
        vecs[3]  = '{1'b1, 16'h007F, 8'h00, 1'b1, 1'b1, 8'h3C};
        vecs[4]  = '{1'b0, 16'h0000, 8'hC3, 1'b1, 1'b1, 8'h3C};
        vecs[5]  = '{1'b1, 16'h0000, 8'h00, 1'b1, 1'b1, 8'hC3};
        vecs[6]  = '{1'b0, 16'h0080, 8'hFF, 1'b1, 1'b0, 8'hC3};
        vecs[7]  = '{1'b1, 16'h0000, 8'h00, 1'b1, 1'b1, 8'hC3};
        vecs[8]  = '{1'b1, 16'hFFFF, 8'h00, 1'b1, 1'b0, 8'hC3};
        vecs[9]  = '{1'b0, 16'h0042, 8'h11, 1'b0, 1'b0, 8'hC3};
        vecs[10] = '{1'b1, 16'h007F, 8'h00, 1'b1, 1'b1, 8'h3C};
        vecs[11] = '{1'b0, 16'h1042, 8'h77, 1'b1, 1'b0, 8'h3C};
        vecs[12] = '{1'b1, 16'h0042, 8'h00, 1'b1, 1'b1, 8'hA5};

        bus.cpu_addr = 16'h0000; bus.cpu_vma = 1'b0; bus.cpu_rw = 1'b1;
        bus.cpu_e = 1'b0; bus.cpu_wdata = 8'h00;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_ram_cs", {31'd0, ram_cs}, 32'd0);
        check("rst_ram_rw", {31'd0, ram_rw}, 32'd1);
        check("rst_ram_address", {25'd0, ram_address}, 32'd0);
        check("rst_ram_wdata", {24'd0, ram_wdata}, 32'd0);
        check("rst_cpu_ack", {31'd0, bus.cpu_ack}, 32'd0);
        check("rst_cpu_rdata", {24'd0, bus.cpu_rdata}, 32'd0);
        rst_n = 1'b1;

`ifdef SOUND_RAM_CLEAR_EN
        for (int pass = 0; pass < 2; pass++) begin
            int wait_n;
            wait_n = 0;
            check("clr_busy_done", {31'd0, clear_done}, 32'd0);
            check("clr_busy_ready", {31'd0, bus.cpu_ready}, 32'd0);
            while (!ram_cs && wait_n < 5) begin
                @(negedge clk); wait_n++;
            end
            check("clr_start", {31'd0, ram_cs}, 32'd1);
            ok = 1'b1;
            for (int i = 0; i < 128; i++) begin
                if (pass == 0 && i == 50) begin
                    rst_n = 1'b0;
                    @(negedge clk);
                    check("clr_rst_cs", {31'd0, ram_cs}, 32'd0);
                    rst_n = 1'b1;
                    break;
                end
                if (!(ram_cs && !ram_rw && ram_address == i[6:0] && ram_wdata == 8'h00 &&
                      !clear_done && !bus.cpu_ready)) ok = 1'b0;
                @(negedge clk);
            end
            if (pass == 1) begin
                check("clr_128_cycles", {31'd0, ok}, 32'd1);
                check("clr_end_cs", {31'd0, ram_cs}, 32'd0);
                @(negedge clk);
                check("clr_done", {31'd0, clear_done}, 32'd1);
                check("clr_ready", {31'd0, bus.cpu_ready}, 32'd1);
                check("clr_mem_7f", {24'd0, mem[127]}, 32'd0);
            end
        end
`else
        @(negedge clk);
        check("noclr_done", {31'd0, clear_done}, 32'd1);
        check("noclr_ready", {31'd0, bus.cpu_ready}, 32'd1);
        cs_n = 0;
        repeat (5) begin
            @(negedge clk);
            if (ram_cs) cs_n++;
        end
        check("noclr_no_cs", cs_n, 32'd0);
`endif

        // Table-driven single accesses
        for (int v = 0; v < 13; v++) begin
            access(vecs[v].rw, vecs[v].addr, vecs[v].wd, vecs[v].vma, ack_at, cs_n, cs_addr, cs_wd);
            check($sformatf("v%0d_cs_count", v), cs_n, vecs[v].hit ? 32'd1 : 32'd0);
            check($sformatf("v%0d_ack_at", v), ack_at,
                  vecs[v].hit ? (vecs[v].rw ? 32'd2 : 32'd1) : 32'hFFFF_FFFF);
            if (vecs[v].hit) check($sformatf("v%0d_ram_addr", v), {25'd0, cs_addr}, {25'd0, vecs[v].addr[6:0]});
            if (vecs[v].hit && !vecs[v].rw) check($sformatf("v%0d_ram_wdata", v), {24'd0, cs_wd}, {24'd0, vecs[v].wd});
            check($sformatf("v%0d_cpu_rdata", v), {24'd0, bus.cpu_rdata}, {24'd0, vecs[v].rd});
        end
        check("mem_42", {24'd0, mem[7'h42]}, 32'hA5);

        // Second strobe one cycle after a read strobe is dropped
        bus.cpu_rw = 1'b1; bus.cpu_addr = 16'h0042; bus.cpu_vma = 1'b1; bus.cpu_e = 1'b1;
        @(negedge clk);
        check("drop_ready_low", {31'd0, bus.cpu_ready}, 32'd0);
        bus.cpu_rw = 1'b0; bus.cpu_addr = 16'h0010; bus.cpu_wdata = 8'h99;
        cs_n = 1; acks = 0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            if (j == 0) bus.cpu_e = 1'b0;
            if (ram_cs) cs_n++;
            if (bus.cpu_ack) acks++;
        end
        check("drop_cs_pulses", cs_n, 32'd1);
        check("drop_acks", acks, 32'd1);
        check("drop_rdata", {24'd0, bus.cpu_rdata}, 32'hA5);
        check("drop_mem_10", {24'd0, mem[7'h10]}, 32'h00);

        // Reset during a write abandons it without ack
        bus.cpu_rw = 1'b0; bus.cpu_addr = 16'h0005; bus.cpu_wdata = 8'h5A; bus.cpu_e = 1'b1;
        @(negedge clk);
        bus.cpu_e = 1'b0;
        check("midwr_cs", {31'd0, ram_cs}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midwr_rst_cs", {31'd0, ram_cs}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        acks = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.cpu_ack) acks++;
        end
`ifdef SOUND_RAM_CLEAR_EN
        repeat (140) @(negedge clk);
`endif
        check("midwr_no_ack", acks, 32'd0);
        check("midwr_rdata_reset", {24'd0, bus.cpu_rdata}, 32'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
